// File: rtl/axi_enhanced_rx_dsc_switch.sv
// Final RX output stage: registers upstream beats onto m_axis_rx_*, pads a discontinued
// multi-beat packet with null-generator beats, then discards the rest of that packet.
module axi_enhanced_rx_dsc_switch #(
  parameter int C_DATA_WIDTH = 128,
  parameter int TCQ          = 1,
  parameter int STRB_WIDTH   = C_DATA_WIDTH / 8
) (
  input  logic                    com_iclk,
  input  logic                    com_sysrst_n,

  input  logic [C_DATA_WIDTH-1:0] in_tdata,
  input  logic                    in_tvalid,
  input  logic                    in_tlast,
  input  logic [STRB_WIDTH-1:0]   in_tstrb,
  input  logic [21:0]             in_tuser,
  input  logic                    in_dsc,
  output logic                    in_tready,

  input  logic                    null_rx_tvalid,
  input  logic                    null_rx_tlast,
  input  logic [STRB_WIDTH-1:0]   null_rx_tstrb,
  input  logic [4:0]              null_is_eof,

  output logic [C_DATA_WIDTH-1:0] m_axis_rx_tdata,
  output logic                    m_axis_rx_tvalid,
  output logic                    m_axis_rx_tlast,
  output logic [STRB_WIDTH-1:0]   m_axis_rx_tstrb,
  output logic [21:0]             m_axis_rx_tuser,
  input  logic                    m_axis_rx_tready,

  output logic [7:0]              dsc_count
);

  typedef enum logic [1:0] {
    PASS      = 2'd0,
    NULL_FILL = 2'd1,
    DROP      = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic in_pkt;
  logic up_eof_seen;
  logic load_en;
  logic accept;
  logic in_eof;
  logic load_pass;
  logic load_null;
  logic dsc_evt;
  logic enter_null;

  // TCQ is kept for parameter compatibility with the rest of the core; unused here.
  logic unused_tcq;
  assign unused_tcq = TCQ[0];

  assign load_en = !m_axis_rx_tvalid || m_axis_rx_tready;
  assign in_eof  = in_tuser[21];
  assign accept  = in_tvalid && in_tready;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nxt  = state;
    in_tready  = 1'b0;
    load_pass  = 1'b0;
    load_null  = 1'b0;
    dsc_evt    = 1'b0;
    enter_null = 1'b0;

    unique case (state)
      PASS: begin
        in_tready = load_en;
        if (in_tvalid && load_en) begin
          if (!in_dsc) begin
            load_pass = 1'b1;
          end else begin
            dsc_evt = 1'b1;
            if (in_pkt) begin
              enter_null = 1'b1;
              state_nxt  = NULL_FILL;
            end else if (!in_eof) begin
              state_nxt = DROP;
            end
          end
        end
      end
      NULL_FILL: begin
        if (load_en && null_rx_tvalid) begin
          load_null = 1'b1;
          if (null_rx_tlast) state_nxt = up_eof_seen ? PASS : DROP;
        end
      end
      DROP: begin
        in_tready = 1'b1;
        if (in_tvalid && in_eof) state_nxt = PASS;
      end
      default: state_nxt = PASS;
    endcase

    // Upstream must see backpressure for the whole time reset is held.
    if (!com_sysrst_n) in_tready = 1'b0;
  end

  // NOTE: sequential state is written only with non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge com_iclk or negedge com_sysrst_n) begin
    if (!com_sysrst_n) begin
      state       <= PASS;
      in_pkt      <= 1'b0;
      up_eof_seen <= 1'b0;
      dsc_count   <= 8'd0;
    end else begin
      state <= state_nxt;
      if (accept) in_pkt <= !in_eof;
      if (enter_null) up_eof_seen <= in_eof;
      if (dsc_evt && (dsc_count != 8'hFF)) dsc_count <= dsc_count + 8'd1;
    end
  end

  // NOTE: the data path is reset too, because downstream and the null generator's shadow
  // inputs observe these registers directly and must see all-zero beats out of reset.
  always_ff @(posedge com_iclk or negedge com_sysrst_n) begin
    if (!com_sysrst_n) begin
      m_axis_rx_tdata  <= '0;
      m_axis_rx_tvalid <= 1'b0;
      m_axis_rx_tlast  <= 1'b0;
      m_axis_rx_tstrb  <= '0;
      m_axis_rx_tuser  <= '0;
    end else if (load_en) begin
      m_axis_rx_tvalid <= load_pass || load_null;
      if (load_pass) begin
        m_axis_rx_tdata <= in_tdata;
        m_axis_rx_tlast <= in_tlast;
        m_axis_rx_tstrb <= in_tstrb;
        m_axis_rx_tuser <= in_tuser;
      end else if (load_null) begin
        // Padding beat: zero payload, null-gen eof position, error-forward set.
        m_axis_rx_tdata <= '0;
        m_axis_rx_tlast <= null_rx_tlast;
        m_axis_rx_tstrb <= null_rx_tstrb;
        m_axis_rx_tuser <= {null_is_eof, 15'd0, 1'b1, 1'b0};
      end
    end
  end

endmodule
